// File: rtl/io_port_ctrl.sv
// io_port_ctrl -- host <-> CPU I/O port bridge built from two small FIFOs.
//
// Input path : host pushes words (valid/ready); the CPU sees the oldest word
//              on cpu_in_port and consumes it with a one-cycle cpu_in_ack pulse.
//              When the FIFO is empty, cpu_in_port keeps showing the last word
//              the CPU consumed (hold register).
// Output path: the CPU writes with a one-cycle cpu_out_we pulse. The host drains
//              with valid/ready. A write into a full FIFO is dropped unless the
//              host pops on the same edge.
//
// Ports
//   clk, rst                         single clock, async active-high reset
//   host_in_data/valid/ready         host -> input FIFO
//   cpu_in_port, cpu_in_ack          input FIFO -> CPU in_port
//   cpu_out_port, cpu_out_we         CPU out_port -> output FIFO
//   host_out_data/valid/ready        output FIFO -> host
//   out_overflow                     sticky "CPU output word dropped" flag
//
// Build option
//   IO_OUT_OVERFLOW_FLAG_EN  defined : out_overflow sets on a dropped word and
//                                      holds until rst.
//                            undefined: out_overflow is tied low, no flag flop.

// Circular FIFO with one extra pointer bit to tell full from empty.
// Push/pop qualification is the caller's job; this block only guards
// against popping empty / pushing full so the pointers can never slip.
module io_port_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // A push into a full FIFO is legal only when the same edge frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: it is only visible through non-empty pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

module io_port_ctrl #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] host_in_data,
  input  logic             host_in_valid,
  output logic             host_in_ready,
  output logic [WIDTH-1:0] cpu_in_port,
  input  logic             cpu_in_ack,
  input  logic [WIDTH-1:0] cpu_out_port,
  input  logic             cpu_out_we,
  output logic [WIDTH-1:0] host_out_data,
  output logic             host_out_valid,
  input  logic             host_out_ready,
  output logic             out_overflow
);
  // ---------------- input path ----------------
  logic [WIDTH-1:0] in_head, hold;
  logic             in_full, in_empty, in_push, in_pop;

  assign host_in_ready = !in_full;
  assign in_push       = host_in_valid && !in_full;
  assign in_pop        = cpu_in_ack && !in_empty;  // ack on empty is ignored

  io_port_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_in_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_push),
    .wdata (host_in_data),
    .pop   (in_pop),
    .rdata (in_head),
    .full  (in_full),
    .empty (in_empty)
  );

  // Keeps the last consumed word so a repeated IN reads a stable value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         hold <= '0;
    else if (in_pop) hold <= in_head;
  end

  assign cpu_in_port = in_empty ? hold : in_head;

  // ---------------- output path ----------------
  logic out_full, out_empty, out_pop;

  assign host_out_valid = !out_empty;
  assign out_pop        = host_out_ready && !out_empty;

  io_port_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cpu_out_we),
    .wdata (cpu_out_port),
    .pop   (out_pop),
    .rdata (host_out_data),
    .full  (out_full),
    .empty (out_empty)
  );

`ifdef IO_OUT_OVERFLOW_FLAG_EN
  logic ovf_q, out_drop;

  // Same condition the FIFO uses to refuse the write.
  assign out_drop = cpu_out_we && out_full && !out_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ovf_q <= 1'b0;
    else if (out_drop) ovf_q <= 1'b1;
  end

  assign out_overflow = ovf_q;
`else
  // Words are still dropped on a full FIFO; the event just is not reported.
  assign out_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_io_port_ctrl.sv
module tb_io_port_ctrl;
  localparam int DEPTH = 4;
  localparam int WIDTH = 16;
`ifdef IO_OUT_OVERFLOW_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] host_in_data = '0;
  logic             host_in_valid = 1'b0;
  logic             host_in_ready;
  logic [WIDTH-1:0] cpu_in_port;
  logic             cpu_in_ack = 1'b0;
  logic [WIDTH-1:0] cpu_out_port = '0;
  logic             cpu_out_we = 1'b0;
  logic [WIDTH-1:0] host_out_data;
  logic             host_out_valid;
  logic             host_out_ready = 1'b0;
  logic             out_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  io_port_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .host_in_data   (host_in_data),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .cpu_in_port    (cpu_in_port),
    .cpu_in_ack     (cpu_in_ack),
    .cpu_out_port   (cpu_out_port),
    .cpu_out_we     (cpu_out_we),
    .host_out_data  (host_out_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .out_overflow   (out_overflow)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    host_in_valid = 1'b0; cpu_in_ack = 1'b0; cpu_out_we = 1'b0; host_out_ready = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    n_checks++; if (host_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", host_in_ready); end
    n_checks++; if (cpu_in_port !== 16'h0) begin n_fail++; $display("FAIL reset_cpu_in got=%h exp=0000", cpu_in_port); end
    n_checks++; if (host_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", host_out_valid); end
    n_checks++; if (out_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", out_overflow); end
    rst = 1'b0;
    tick();
    n_checks++; if (host_in_ready !== 1'b1 || host_out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset got ready=%b valid=%b exp 1/0", host_in_ready, host_out_valid); end
  endtask

  task automatic test_in_basic();
    host_in_data = 16'h0014; host_in_valid = 1'b1;
    tick();
    host_in_valid = 1'b0;
    n_checks++; if (cpu_in_port !== 16'h0014) begin n_fail++; $display("FAIL in_latency got=%h exp=0014", cpu_in_port); end
    cpu_in_ack = 1'b1;
    tick();
    cpu_in_ack = 1'b0;
    n_checks++; if (cpu_in_port !== 16'h0014) begin n_fail++; $display("FAIL in_hold got=%h exp=0014", cpu_in_port); end
    // If the FIFO were not empty the old head would still be shown.
    host_in_data = 16'h0022; host_in_valid = 1'b1;
    tick();
    host_in_valid = 1'b0;
    n_checks++; if (cpu_in_port !== 16'h0022) begin n_fail++; $display("FAIL in_empty_after_ack got=%h exp=0022", cpu_in_port); end
    cpu_in_ack = 1'b1;
    tick();
    cpu_in_ack = 1'b0;
  endtask

  task automatic test_in_full();
    for (int i = 1; i <= 4; i++) begin
      host_in_data = WIDTH'(i); host_in_valid = 1'b1;
      tick();
    end
    n_checks++; if (host_in_ready !== 1'b0) begin n_fail++; $display("FAIL in_full_ready got=%b exp=0", host_in_ready); end
    host_in_data = 16'h0005;
    tick();  // rejected
    host_in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      n_checks++; if (cpu_in_port !== WIDTH'(i)) begin n_fail++; $display("FAIL in_order[%0d] got=%h exp=%h", i, cpu_in_port, WIDTH'(i)); end
      cpu_in_ack = 1'b1;
      tick();
    end
    tick();  // extra ack on empty must be ignored
    cpu_in_ack = 1'b0;
    n_checks++; if (cpu_in_port !== 16'h0004) begin n_fail++; $display("FAIL in_fifth_rejected got=%h exp=0004", cpu_in_port); end
    n_checks++; if (host_in_ready !== 1'b1) begin n_fail++; $display("FAIL in_ready_after_drain got=%b exp=1", host_in_ready); end
  endtask

  task automatic test_out_basic();
    cpu_out_port = 16'hBEEF; cpu_out_we = 1'b1;
    tick();
    cpu_out_port = 16'h1234;
    tick();
    cpu_out_we = 1'b0;
    n_checks++; if (host_out_valid !== 1'b1 || host_out_data !== 16'hBEEF) begin n_fail++; $display("FAIL out_first got=%b/%h exp=1/beef", host_out_valid, host_out_data); end
    host_out_ready = 1'b1;
    tick();
    n_checks++; if (host_out_valid !== 1'b1 || host_out_data !== 16'h1234) begin n_fail++; $display("FAIL out_second got=%b/%h exp=1/1234", host_out_valid, host_out_data); end
    tick();
    host_out_ready = 1'b0;
    n_checks++; if (host_out_valid !== 1'b0) begin n_fail++; $display("FAIL out_empty got=%b exp=0", host_out_valid); end
  endtask

  task automatic test_out_overflow();
    for (int i = 0; i < 5; i++) begin
      cpu_out_port = WIDTH'(16'h000A + i); cpu_out_we = 1'b1;
      tick();
    end
    cpu_out_we = 1'b0;
    n_checks++; if (out_overflow !== OVF_EN) begin n_fail++; $display("FAIL out_ovf_flag got=%b exp=%b", out_overflow, OVF_EN); end
    host_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (host_out_valid !== 1'b1 || host_out_data !== WIDTH'(16'h000A + i)) begin n_fail++; $display("FAIL out_drain[%0d] got=%b/%h exp=1/%h", i, host_out_valid, host_out_data, WIDTH'(16'h000A + i)); end
      tick();
    end
    host_out_ready = 1'b0;
    n_checks++; if (host_out_valid !== 1'b0) begin n_fail++; $display("FAIL out_drop_0e got=%b exp=0", host_out_valid); end
    n_checks++; if (out_overflow !== OVF_EN) begin n_fail++; $display("FAIL out_ovf_sticky got=%b exp=%b", out_overflow, OVF_EN); end
  endtask

  task automatic test_out_full_pop();
    logic [WIDTH-1:0] exp_seq [4];
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      cpu_out_port = WIDTH'(16'h0040 + i); cpu_out_we = 1'b1;
      tick();
    end
    cpu_out_port = 16'h0055; host_out_ready = 1'b1;
    tick();
    cpu_out_we = 1'b0;
    n_checks++; if (out_overflow !== 1'b0) begin n_fail++; $display("FAIL full_pop_ovf got=%b exp=0", out_overflow); end
    exp_seq[0] = 16'h0041; exp_seq[1] = 16'h0042; exp_seq[2] = 16'h0043; exp_seq[3] = 16'h0055;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (host_out_valid !== 1'b1 || host_out_data !== exp_seq[i]) begin n_fail++; $display("FAIL full_pop_drain[%0d] got=%b/%h exp=1/%h", i, host_out_valid, host_out_data, exp_seq[i]); end
      tick();
    end
    host_out_ready = 1'b0;
    n_checks++; if (host_out_valid !== 1'b0) begin n_fail++; $display("FAIL full_pop_empty got=%b exp=0", host_out_valid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      host_in_data = WIDTH'(16'h0100 + i); host_in_valid = 1'b1;
      cpu_out_port = WIDTH'(16'h0200 + i); cpu_out_we = 1'b1;
      tick();
    end
    cpu_in_ack = 1'b1;
    tick();  // hold now nonzero, FIFOs still populated
    idle();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (host_in_ready !== 1'b1 || cpu_in_port !== 16'h0 || host_out_valid !== 1'b0 || out_overflow !== 1'b0)
      begin n_fail++; $display("FAIL async_reset got ready=%b in=%h oval=%b ovf=%b", host_in_ready, cpu_in_port, host_out_valid, out_overflow); end
    // Handshakes on edges while reset is held do nothing.
    host_in_data = 16'h0777; host_in_valid = 1'b1; cpu_out_we = 1'b1; cpu_out_port = 16'h0888;
    @(posedge clk); #1;
    idle();
    n_checks++; if (cpu_in_port !== 16'h0 || host_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_edge_ignored got in=%h oval=%b exp 0000/0", cpu_in_port, host_out_valid); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] inq[$];
    logic [WIDTH-1:0] outq[$];
    logic [WIDTH-1:0] hold_m;
    bit               ovf_m;
    bit               ipop, opop;
    apply_reset();
    hold_m = '0; ovf_m = 1'b0;
    for (int c = 0; c < 600; c++) begin
      host_in_data   = WIDTH'($urandom);
      host_in_valid  = ($urandom_range(0, 3) != 0);
      cpu_in_ack     = ($urandom_range(0, 2) == 0);
      cpu_out_port   = WIDTH'($urandom);
      cpu_out_we     = ($urandom_range(0, 2) != 0);
      host_out_ready = ($urandom_range(0, 2) == 0);
      #1;
      n_checks++; if (host_in_ready !== (inq.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, host_in_ready, inq.size() < DEPTH); end
      n_checks++; if (cpu_in_port !== ((inq.size() > 0) ? inq[0] : hold_m)) begin n_fail++; $display("FAIL rnd_cpu_in c=%0d got=%h exp=%h", c, cpu_in_port, (inq.size() > 0) ? inq[0] : hold_m); end
      n_checks++; if (host_out_valid !== (outq.size() > 0)) begin n_fail++; $display("FAIL rnd_out_valid c=%0d got=%b exp=%b", c, host_out_valid, outq.size() > 0); end
      if (outq.size() > 0) begin
        n_checks++; if (host_out_data !== outq[0]) begin n_fail++; $display("FAIL rnd_out_data c=%0d got=%h exp=%h", c, host_out_data, outq[0]); end
      end
      n_checks++; if (out_overflow !== ovf_m) begin n_fail++; $display("FAIL rnd_ovf c=%0d got=%b exp=%b", c, out_overflow, ovf_m); end
      // Reference update using pre-edge occupancy.
      ipop = cpu_in_ack && (inq.size() > 0);
      opop = host_out_ready && (outq.size() > 0);
      if (host_in_valid && inq.size() < DEPTH) inq.push_back(host_in_data);
      if (ipop) hold_m = inq.pop_front();
      if (cpu_out_we && (outq.size() < DEPTH || opop)) outq.push_back(cpu_out_port);
      else if (cpu_out_we) ovf_m = OVF_EN;
      if (opop) void'(outq.pop_front());
      @(posedge clk); #1;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_in_basic();
    test_in_full();
    test_out_basic();
    test_out_overflow();
    test_out_full_pop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/io_port_ctrl.md
IO_PORT_CTRL -- requirements
Module: io_port_ctrl

Interface
REQ-001 Parameter DEPTH, 4, entries per FIFO; power of two, minimum 2.
REQ-002 Parameter WIDTH, 16, data width; matches the CPU in_port/out_port width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 host_in_data  input  WIDTH  word offered to the CPU input port.
REQ-006 host_in_valid  input  1  host_in_data valid.
REQ-007 host_in_ready  output  1  input FIFO can accept a word.
REQ-008 cpu_in_port  output  WIDTH  value presented to CPU in_port.
REQ-009 cpu_in_ack  input  1  one-cycle pulse: CPU executed IN and consumed cpu_in_port.
REQ-010 cpu_out_port  input  WIDTH  CPU out_port value.
REQ-011 cpu_out_we  input  1  one-cycle pulse: CPU executed OUT; cpu_out_port valid.
REQ-012 host_out_data  output  WIDTH  oldest captured CPU output word.
REQ-013 host_out_valid  output  1  output FIFO non-empty.
REQ-014 host_out_ready  input  1  host accepts host_out_data.
REQ-015 out_overflow  output  1  sticky: a CPU output word was dropped.

Function
REQ-016 Both FIFOs SHALL use read/write pointers of log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; full = MSBs differ and low bits equal; empty = pointers equal.
REQ-017 Input push SHALL occur when host_in_valid && host_in_ready; host_in_ready SHALL equal !in_full, combinationally.
REQ-018 cpu_in_port SHALL show the input FIFO head while non-empty, otherwise a hold register containing the last popped word.
REQ-019 cpu_in_ack while input FIFO non-empty SHALL pop the head and load it into the hold register; cpu_in_ack while empty SHALL be ignored.
REQ-020 A word pushed into an empty input FIFO SHALL appear on cpu_in_port in the cycle after the push edge (one-cycle latency).
REQ-021 Push and pop on the same edge SHALL both complete when legal; count unchanged.
REQ-022 cpu_out_we SHALL push cpu_out_port into the output FIFO when not full, or when full and a host pop occurs on the same edge.
REQ-023 cpu_out_we while full with no simultaneous pop SHALL drop the word; FIFO contents unchanged.
REQ-024 host_out_valid SHALL equal !out_empty; host_out_data SHALL equal the head; pop on host_out_valid && host_out_ready.
REQ-025 Ordering SHALL be strict FIFO in both directions; no word duplicated or reordered across pointer wrap.

Reset
REQ-026 rst SHALL asynchronously clear all pointers, the hold register, and out_overflow to zero.
REQ-027 During and after reset: host_in_ready=1, cpu_in_port=0, host_out_valid=0, host_out_data don't-care, out_overflow=0.
REQ-028 Reset asserted mid-transfer SHALL discard all FIFO contents; handshakes on the reset edge SHALL have no effect.

Configuration
REQ-029 Macro IO_OUT_OVERFLOW_FLAG_EN defined: out_overflow SHALL set on the edge following a dropped word (REQ-023) and hold until rst.
REQ-030 Macro undefined: out_overflow SHALL be tied to 0 and no flag register SHALL be present; dropping behaviour unchanged.

Verification
REQ-031 Push 0x0014 into empty input FIFO -> cpu_in_port=0x0014 next cycle; cpu_in_ack -> FIFO empty, cpu_in_port holds 0x0014.
REQ-032 Push 0x0001..0x0004 with no ack -> host_in_ready=0; fifth push rejected; four acks -> cpu_in_port sequence 0x0001..0x0004.
REQ-033 cpu_out_we with cpu_out_port 0xBEEF, 0x1234, host_out_ready=1 after both -> host receives 0xBEEF then 0x1234, then host_out_valid=0.
REQ-034 Five cpu_out_we (0x0A..0x0E) with host_out_ready=0 -> 0x0E dropped, out_overflow=1 (macro on) / 0 (macro off); drain yields 0x0A..0x0D.
REQ-035 Output FIFO full, cpu_out_we 0x55 with host pop on same edge -> 0x55 accepted, no overflow.
REQ-036 rst pulsed with both FIFOs holding data -> all outputs return to REQ-027 values immediately, before the next clock edge.
